// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the 5-stage RV32I core.
// The decode control bundle, operands, PC, immediate and register indices are
// captured on each rising edge. StallE holds the register. FlushE inserts a bubble.
// The load-use hazard request is decoded from the registered E state and the
// current decode indices.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic                      ValidD,
  input  logic                      RegWriteD,
  input  logic [1:0]                ResultSrcD,
  input  logic                      MemWriteD,
  input  logic                      JumpD,
  input  logic                      BranchD,
  input  logic [3:0]                ALUControlD,
  input  logic                      ALUSrcD,
  input  logic                      JALRInstrD,
  input  logic [2:0]                AddressingControlD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  output logic                      ValidE,
  output logic                      RegWriteE,
  output logic [1:0]                ResultSrcE,
  output logic                      MemWriteE,
  output logic                      JumpE,
  output logic                      BranchE,
  output logic [3:0]                ALUControlE,
  output logic                      ALUSrcE,
  output logic                      JALRInstrE,
  output logic [2:0]                AddressingControlE,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [DATA_WIDTH-1:0]     PCPlus4E,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      LoadUseStallD
);

  // ResultSrc encoding that selects memory read data, i.e. a load.
  localparam logic [1:0] RESULT_MEM = 2'b01;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic [3:0] aluctrl;
    logic       alusrc;
    logic       jalr;
    logic [2:0] addrctrl;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pcplus4;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } data_t;

  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;
  logic  vld_q;

  // Decode control is squashed when the D slot is empty. This keeps a stale
  // RegWrite or MemWrite from a killed slot out of execute.
  always_comb begin
    ctrl_d = '0;
    if (ValidD) begin
      ctrl_d.regwrite  = RegWriteD;
      ctrl_d.resultsrc = ResultSrcD;
      ctrl_d.memwrite  = MemWriteD;
      ctrl_d.jump      = JumpD;
      ctrl_d.branch    = BranchD;
      ctrl_d.aluctrl   = ALUControlD;
      ctrl_d.alusrc    = ALUSrcD;
      ctrl_d.jalr      = JALRInstrD;
      ctrl_d.addrctrl  = AddressingControlD;
    end
  end

  // Data and index fields pass through untouched, even for an empty slot.
  always_comb begin
    data_d         = '0;
    data_d.rd1     = RD1D;
    data_d.rd2     = RD2D;
    data_d.pc      = PCD;
    data_d.imm     = ImmExtD;
    data_d.pcplus4 = PCPlus4D;
    data_d.rs1     = Rs1D;
    data_d.rs2     = Rs2D;
    data_d.rd      = RdD;
  end

  // Slot valid bit: reset and flush produce a bubble, stall holds, otherwise follow D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_q <= 1'b0;
    else if (FlushE)  vld_q <= 1'b0;
    else if (!StallE) vld_q <= ValidD;
  end

  // Control register. Flush wins over stall so that a bubble can be forced
  // while the front end is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ctrl_q <= '0;
    else if (FlushE)  ctrl_q <= '0;
    else if (!StallE) ctrl_q <= ctrl_d;
  end

  // Data/index register. A flush also zeroes it, so a bubble reads as all-zero
  // and RdE=0 cannot alias a real destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       data_q <= '0;
    else if (FlushE)  data_q <= '0;
    else if (!StallE) data_q <= data_d;
  end

  assign ValidE             = vld_q;
  assign RegWriteE          = ctrl_q.regwrite;
  assign ResultSrcE         = ctrl_q.resultsrc;
  assign MemWriteE          = ctrl_q.memwrite;
  assign JumpE              = ctrl_q.jump;
  assign BranchE            = ctrl_q.branch;
  assign ALUControlE        = ctrl_q.aluctrl;
  assign ALUSrcE            = ctrl_q.alusrc;
  assign JALRInstrE         = ctrl_q.jalr;
  assign AddressingControlE = ctrl_q.addrctrl;
  assign RD1E               = data_q.rd1;
  assign RD2E               = data_q.rd2;
  assign PCE                = data_q.pc;
  assign ImmExtE            = data_q.imm;
  assign PCPlus4E           = data_q.pcplus4;
  assign Rs1E               = data_q.rs1;
  assign Rs2E               = data_q.rs2;
  assign RdE                = data_q.rd;

  // Load-use detect. rs2 is compared for every opcode, so an instruction that
  // has no rs2 may stall for one cycle it did not need. A load to x0 never stalls.
  logic load_e, rd_nz, idx_hit;
  always_comb begin
    load_e        = vld_q & (ctrl_q.resultsrc == RESULT_MEM);
    rd_nz         = (data_q.rd != '0);
    idx_hit       = (Rs1D == data_q.rd) | (Rs2D == data_q.rd);
    LoadUseStallD = load_e & ValidD & rd_nz & idx_hit;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for the ID/EX pipeline register.
// The table covers capture, stall, flush and load-use. Hand sequences cover the
// remaining fields, invalid capture and asynchronous reset.
module tb_id_ex_stage;

  logic clk, rst_n;
  logic StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRInstrD;
  logic [1:0]  ResultSrcD;
  logic [3:0]  ALUControlD;
  logic [2:0]  AddressingControlD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRInstrE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  AddressingControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic LoadUseStallD;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .JALRInstrD(JALRInstrD),
    .AddressingControlD(AddressingControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .JALRInstrE(JALRInstrE), .AddressingControlE(AddressingControlE), .RD1E(RD1E),
    .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .RdE(RdE), .LoadUseStallD(LoadUseStallD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every E output, used for the all-zero reset/bubble checks (191 bits).
  logic [190:0] all_e;
  assign all_e = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
                  ALUSrcE, JALRInstrE, AddressingControlE, RD1E, RD2E, PCE, ImmExtE,
                  PCPlus4E, Rs1E, Rs2E, RdE};
  // Subset compared by the table (79 bits).
  logic [78:0] tbl_e;
  assign tbl_e = {ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUControlE, RD1E, PCE, RdE};

  typedef struct {
    string       name;
    logic        st, fl, v, rw;
    logic [1:0]  rs;
    logic        mw, br;
    logic [3:0]  alu;
    logic [31:0] rd1, pc;
    logic [4:0]  rs1, rs2, rd;
    logic        pre_lus;
    logic [78:0] exp_e;
    logic        post_lus;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [78:0] ee(logic v, logic rw, logic [1:0] rs, logic mw, logic br,
                                     logic [3:0] alu, logic [31:0] rd1, logic [31:0] pc,
                                     logic [4:0] rd);
    return {v, rw, rs, mw, br, alu, rd1, pc, rd};
  endfunction

  function automatic vec_t mk(string n, logic st, logic fl, logic v, logic rw, logic [1:0] rs,
                              logic mw, logic br, logic [3:0] alu, logic [31:0] rd1,
                              logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic pre, logic [78:0] e, logic post);
    vec_t t;
    t.name = n; t.st = st; t.fl = fl; t.v = v; t.rw = rw; t.rs = rs; t.mw = mw; t.br = br;
    t.alu = alu; t.rd1 = rd1; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.pre_lus = pre; t.exp_e = e; t.post_lus = post;
    return t;
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_zero();
    StallE = 0; FlushE = 0; ValidD = 0; RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0;
    JumpD = 0; BranchD = 0; ALUControlD = 0; ALUSrcD = 0; JALRInstrD = 0;
    AddressingControlD = 0; RD1D = 0; RD2D = 0; PCD = 0; ImmExtD = 0; PCPlus4D = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_zero();

    // Stimulus/expectation table. E state is traced row by row by hand.
    tbl[0]  = mk("add_x3",      0,0,1,1,2'b00,0,0,4'h0,32'd10,      32'h10,      5'd1, 5'd2, 5'd3, 0,
                 ee(1,1,2'b00,0,0,4'h0,32'd10,32'h10,5'd3), 0);
    tbl[1]  = mk("lw_x5",       0,0,1,1,2'b01,0,0,4'h0,32'd100,     32'h14,      5'd1, 5'd0, 5'd5, 0,
                 ee(1,1,2'b01,0,0,4'h0,32'd100,32'h14,5'd5), 0);
    tbl[2]  = mk("use_flush",   0,1,1,1,2'b00,0,0,4'h0,32'd7,       32'h18,      5'd5, 5'd1, 5'd6, 1,
                 ee(0,0,2'b00,0,0,4'h0,32'd0,32'h0,5'd0), 0);
    tbl[3]  = mk("use_retry",   0,0,1,1,2'b00,0,0,4'h0,32'd7,       32'h18,      5'd5, 5'd1, 5'd6, 0,
                 ee(1,1,2'b00,0,0,4'h0,32'd7,32'h18,5'd6), 0);
    tbl[4]  = mk("lw_x0",       0,0,1,1,2'b01,0,0,4'h0,32'd5,       32'h1c,      5'd2, 5'd0, 5'd0, 0,
                 ee(1,1,2'b01,0,0,4'h0,32'd5,32'h1c,5'd0), 0);
    tbl[5]  = mk("invalid_sw",  0,0,0,0,2'b00,1,0,4'h2,32'h77,      32'h20,      5'd0, 5'd0, 5'd0, 0,
                 ee(0,0,2'b00,0,0,4'h0,32'h77,32'h20,5'd0), 0);
    tbl[6]  = mk("beq",         0,0,1,0,2'b00,0,1,4'h1,32'd1,       32'h40,      5'd4, 5'd5, 5'd0, 0,
                 ee(1,0,2'b00,0,1,4'h1,32'd1,32'h40,5'd0), 0);
    tbl[7]  = mk("stall1",      1,0,1,1,2'b01,1,0,4'h5,32'd99,      32'h80,      5'd6, 5'd7, 5'd9, 0,
                 ee(1,0,2'b00,0,1,4'h1,32'd1,32'h40,5'd0), 0);
    tbl[8]  = mk("stall2",      1,0,1,1,2'b01,1,0,4'h6,32'd98,      32'h84,      5'd6, 5'd7, 5'd10, 0,
                 ee(1,0,2'b00,0,1,4'h1,32'd1,32'h40,5'd0), 0);
    tbl[9]  = mk("stall3",      1,0,1,1,2'b01,1,0,4'h7,32'd97,      32'h88,      5'd6, 5'd7, 5'd11, 0,
                 ee(1,0,2'b00,0,1,4'h1,32'd1,32'h40,5'd0), 0);
    tbl[10] = mk("flush_stall", 1,1,1,1,2'b01,0,0,4'h0,32'h55,      32'h8c,      5'd5, 5'd5, 5'd5, 0,
                 ee(0,0,2'b00,0,0,4'h0,32'd0,32'h0,5'd0), 0);
    tbl[11] = mk("lw_x5_again", 0,0,1,1,2'b01,0,0,4'h0,32'h55,      32'h8c,      5'd5, 5'd5, 5'd5, 0,
                 ee(1,1,2'b01,0,0,4'h0,32'h55,32'h8c,5'd5), 1);
    tbl[12] = mk("max_fields",  0,0,1,1,2'b10,0,0,4'hf,32'hffffffff,32'hfffffffc,5'd31,5'd31,5'd31, 0,
                 ee(1,1,2'b10,0,0,4'hf,32'hffffffff,32'hfffffffc,5'd31), 0);
    tbl[13] = mk("lw_x31",      0,0,1,1,2'b01,0,0,4'h0,32'd0,       32'h100,     5'd0, 5'd0, 5'd31, 0,
                 ee(1,1,2'b01,0,0,4'h0,32'd0,32'h100,5'd31), 0);
    tbl[14] = mk("rs2_hazard",  1,0,1,0,2'b00,1,0,4'h0,32'h1234,    32'h104,     5'd1, 5'd31,5'd0, 1,
                 ee(1,1,2'b01,0,0,4'h0,32'd0,32'h100,5'd31), 1);
    tbl[15] = mk("rs2_invalid", 1,0,0,0,2'b00,1,0,4'h0,32'h1234,    32'h104,     5'd1, 5'd31,5'd0, 0,
                 ee(1,1,2'b01,0,0,4'h0,32'd0,32'h100,5'd31), 0);

    // Reset state
    #12;
    check("reset_all_e", 256'(all_e), 256'(0));
    check("reset_lus", 256'(LoadUseStallD), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table
    for (int i = 0; i < 16; i++) begin
      StallE = tbl[i].st; FlushE = tbl[i].fl; ValidD = tbl[i].v; RegWriteD = tbl[i].rw;
      ResultSrcD = tbl[i].rs; MemWriteD = tbl[i].mw; BranchD = tbl[i].br;
      ALUControlD = tbl[i].alu; RD1D = tbl[i].rd1; RD2D = tbl[i].rd1 + 32'd1;
      PCD = tbl[i].pc; PCPlus4D = tbl[i].pc + 32'd4; Rs1D = tbl[i].rs1; Rs2D = tbl[i].rs2;
      RdD = tbl[i].rd;
      #1;
      check($sformatf("%s pre_lus", tbl[i].name), 256'(LoadUseStallD), 256'(tbl[i].pre_lus));
      tick();
      check($sformatf("%s e_regs", tbl[i].name), 256'(tbl_e), 256'(tbl[i].exp_e));
      check($sformatf("%s post_lus", tbl[i].name), 256'(LoadUseStallD), 256'(tbl[i].post_lus));
    end

    // Remaining fields captured on a valid slot (jalr-like bundle)
    drive_zero();
    ValidD = 1; RegWriteD = 1; ResultSrcD = 2'b10; JumpD = 1; ALUSrcD = 1; JALRInstrD = 1;
    AddressingControlD = 3'b101; RD1D = 32'ha; RD2D = 32'hb; PCD = 32'h200;
    ImmExtD = 32'hfffff800; PCPlus4D = 32'h204; Rs1D = 5'd7; Rs2D = 5'd8; RdD = 5'd1;
    tick();
    check("full_ctrl", 256'({JumpE, ALUSrcE, JALRInstrE, AddressingControlE}), 256'(6'b111101));
    check("full_data", 256'({RD2E, ImmExtE, PCPlus4E}), 256'({32'hb, 32'hfffff800, 32'h204}));
    check("full_idx", 256'({Rs1E, Rs2E, RdE, ValidE}), 256'({5'd7, 5'd8, 5'd1, 1'b1}));

    // Same bundle with an empty slot: controls forced low, data still loads
    ValidD = 0; MemWriteD = 1; RD2D = 32'hc; ImmExtD = 32'h10; PCPlus4D = 32'h208;
    Rs1D = 5'd9; Rs2D = 5'd10; RdD = 5'd11;
    tick();
    check("inv_ctrl", 256'({ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
                            ALUControlE, ALUSrcE, JALRInstrE, AddressingControlE}), 256'(0));
    check("inv_data", 256'({RD2E, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE}),
          256'({32'hc, 32'h10, 32'h208, 5'd9, 5'd10, 5'd11}));

    // Asynchronous reset in the middle of a load-use pair
    drive_zero();
    ValidD = 1; RegWriteD = 1; ResultSrcD = 2'b01; RdD = 5'd5; RD1D = 32'h44; PCD = 32'h300;
    tick();
    Rs1D = 5'd5; Rs2D = 5'd1; RdD = 5'd6; ResultSrcD = 2'b00; PCD = 32'h304;
    #1;
    check("rst_pre_lus", 256'(LoadUseStallD), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_e", 256'(all_e), 256'(0));
    check("rst_async_lus", 256'(LoadUseStallD), 256'(0));
    #2;
    rst_n = 1'b1;
    check("rst_hold_e", 256'({ValidE, RegWriteE, RdE, PCE}), 256'(0));
    tick();
    check("rst_release", 256'({ValidE, RegWriteE, ResultSrcE, RdE, PCE}),
          256'({1'b1, 1'b1, 2'b00, 5'd6, 32'h304}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the 5-stage RV32I core.
- Captures the decode control bundle (RegWrite/ResultSrc/MemWrite/Jump/Branch/ALUControl/ALUSrc/JALRInstr/AddressingControl) plus operands, PC, immediate and register indices.
- Presents them to the execute stage one cycle later, with stall (hold) and flush (bubble) control.
- Generates the load-use hazard stall request back to fetch/decode from its registered state.

Parameters:
- DATA_WIDTH, 32, width of operand, PC and immediate paths.
- REG_ADDR_WIDTH, 5, width of register indices.

Ports:
- clk  input  1  core clock, all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- StallE  input  1  hold all E registers this cycle.
- FlushE  input  1  convert the captured instruction into a bubble.
- ValidD  input  1  decode slot holds a real instruction.
- RegWriteD  input  1  decode control.
- ResultSrcD  input  2  decode control.
- MemWriteD  input  1  decode control.
- JumpD  input  1  decode control.
- BranchD  input  1  decode control.
- ALUControlD  input  4  decode control.
- ALUSrcD  input  1  decode control.
- JALRInstrD  input  1  decode control.
- AddressingControlD  input  3  decode control.
- RD1D  input  DATA_WIDTH  rs1 read data.
- RD2D  input  DATA_WIDTH  rs2 read data.
- PCD  input  DATA_WIDTH  instruction PC.
- ImmExtD  input  DATA_WIDTH  extended immediate.
- PCPlus4D  input  DATA_WIDTH  PC+4.
- Rs1D  input  REG_ADDR_WIDTH  rs1 index.
- Rs2D  input  REG_ADDR_WIDTH  rs2 index.
- RdD  input  REG_ADDR_WIDTH  rd index.
- ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, JALRInstrE, AddressingControlE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE  output  same widths as D counterparts  registered execute-stage copies.
- LoadUseStallD  output  1  combinational load-use hazard request.

Behaviour:
- Reset: rst_n low asynchronously clears every E output to 0, immediately and regardless of clk. Equivalent to a bubble. LoadUseStallD is therefore 0 during reset. Release is synchronous to the next rising edge.
- Latency: one cycle. D inputs sampled at edge N appear on E outputs after edge N.
- Priority per edge: reset > FlushE > StallE > capture.
- FlushE=1 (any StallE): all E outputs become 0, including ValidE, RegWriteE, MemWriteE, JumpE, BranchE, data and indices. The result is a NOP with no architectural side effect.
- StallE=1, FlushE=0: every E register holds its value.
- Capture (both 0): all E registers load their D values.
  - If ValidD=0, the control fields are forced to 0. Data/index fields still load.
  - ValidE takes ValidD.
- Bubble definition: RegWriteE=0, MemWriteE=0, JumpE=0, BranchE=0, ValidE=0. Execute must treat this as no-op.
- LoadUseStallD = ValidE & ValidD & (ResultSrcE==2'b01) & (RdE!=0) & ((Rs1D==RdE) | (Rs2D==RdE)).
  - Purely combinational from current E state and D indices; no internal state.
  - Asserted for exactly one cycle per load-use pair when the hazard controller answers with StallD/StallF plus FlushE on the same edge.
- Rs2D is compared for every opcode. Spurious stalls on instructions without rs2 are allowed (conservative) and cost one cycle.
- Loads to x0 never stall.
- Simultaneous FlushE and a new load in D: the load is discarded, and no stall is requested next cycle.
- Widths: all fields pass through unmodified; no sign handling in this block.

Test Plan:
- Reset mid-operation: load RegWriteE=1, RdE=5, then pull rst_n low between edges -> all E outputs 0 before the next edge; LoadUseStallD=0.
- Normal capture: ValidD=1, add x3,x1,x2 (ALUControlD=0000, RegWriteD=1, RD1D=10, RD2D=20, RdD=3) -> next cycle RegWriteE=1, RD1E=10, RD2E=20, RdE=3, ValidE=1.
- Stall hold: capture beq (BranchD=1, PCD=0x40), then StallE=1 for 3 cycles with changing D inputs -> BranchE=1, PCE=0x40 held throughout.
- Flush over stall: StallE=1 and FlushE=1 together -> next cycle RegWriteE=MemWriteE=JumpE=BranchE=ValidE=0, PCE=0.
- Load-use: E holds lw x5 (ResultSrcE=01, RdE=5); D holds add x6,x5,x1 -> LoadUseStallD=1. Same case with RdE=0 -> 0. Same case with ValidD=0 -> 0.
- Invalid decode: ValidD=0 with MemWriteD=1 -> MemWriteE=0, ValidE=0 after capture.
